// File: rtl/hazard_pkg.sv
// Shared defaults for the scoreboard hazard unit.
// Holds register-file geometry, latency bound and the x0 constant.
package hazard_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int MAX_LAT    = 4;
   localparam int X0_ADDR    = 0;

   function automatic int lat_width(input int max_lat);
      return $clog2(max_lat + 1);
   endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One countdown slot of the hazard scoreboard.
// Holds the cycles remaining until its register's pending write is readable.
module hazard_sb_entry
   import hazard_pkg::*;
#(
   parameter int LAT_W = lat_width(MAX_LAT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [LAT_W-1:0] loadValue,
   output logic             pending,
   output logic [LAT_W-1:0] count
);

   assign pending = (count != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= loadValue;
      end else if (pending) begin
         count <= count - LAT_W'(1);
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: per-register countdown gates decode issue.
// Optional statistics counters enabled by HAZARD_SB_STATS_EN.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W,
   parameter int NUM_REGS   = hazard_pkg::NUM_REGS,
   parameter int MAX_LAT    = hazard_pkg::MAX_LAT,
   parameter int LAT_W      = lat_width(MAX_LAT),
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dec_valid,
   input  logic [REG_ADDR_W-1:0] dec_rs1Address,
   input  logic [REG_ADDR_W-1:0] dec_rs2Address,
   input  logic                  dec_rs1Used,
   input  logic                  dec_rs2Used,
   input  logic [REG_ADDR_W-1:0] dec_rdAddress,
   input  logic                  dec_rdWriteEnable,
   input  logic [LAT_W-1:0]      dec_latency,
   input  logic                  exe_isBranchOrJumpTaken,
   output logic                  dec_issue,
   output logic                  pcWriteEnable,
   output logic                  if_kill,
   output logic                  dec_kill,
   output logic [CNT_W-1:0]      stallCount,
   output logic [CNT_W-1:0]      flushCount
);

   localparam int DEPTH = 1 << REG_ADDR_W;
   localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(X0_ADDR);

   logic [LAT_W-1:0] cnt [DEPTH];
   logic [DEPTH-1:0] pend;
   logic [LAT_W-1:0] lat;
   logic [LAT_W-1:0] load_val;
   logic             raw1;
   logic             raw2;
   logic             waw;
   logic             hazard;
   logic             flush;
   logic             wr;

   // cnt counts from the cycle after issue, so a latency-L result
   // is readable once L-1 further cycles have elapsed.
   always_comb begin
      lat = dec_latency;
      if (dec_latency > LAT_W'(MAX_LAT)) begin
         lat = LAT_W'(MAX_LAT);
      end
      load_val = lat - LAT_W'(1);
   end

   always_comb begin
      raw1   = dec_rs1Used && (dec_rs1Address != X0)
               && pend[dec_rs1Address];
      raw2   = dec_rs2Used && (dec_rs2Address != X0)
               && pend[dec_rs2Address];
      waw    = dec_rdWriteEnable && (dec_rdAddress != X0)
               && (cnt[dec_rdAddress] > lat);
      hazard = dec_valid && (raw1 || raw2 || waw);
      flush  = exe_isBranchOrJumpTaken;
   end

   always_comb begin
      pcWriteEnable = 1'b1;
      if_kill       = 1'b0;
      dec_kill      = 1'b0;
      dec_issue     = dec_valid;
      priority case (1'b1)
         flush: begin
            if_kill   = 1'b1;
            dec_kill  = 1'b1;
            dec_issue = 1'b0;
         end
         hazard: begin
            pcWriteEnable = 1'b0;
            if_kill       = 1'b1;
            dec_kill      = 1'b1;
            dec_issue     = 1'b0;
         end
         default: ;
      endcase
   end

   assign wr = dec_issue && dec_rdWriteEnable
               && (dec_rdAddress != X0) && (lat != '0);

   // Unimplemented address slots read as permanently idle.
   for (genvar r = 0; r < DEPTH; r++) begin : g_slot
      if (r == X0_ADDR || r >= NUM_REGS) begin : g_none
         assign cnt[r]  = '0;
         assign pend[r] = 1'b0;
      end else begin : g_sb
         hazard_sb_entry #(
            .LAT_W(LAT_W)
         ) u_entry (
            .clk(clk),
            .rst(rst),
            .load(wr && (dec_rdAddress == REG_ADDR_W'(r))),
            .loadValue(load_val),
            .pending(pend[r]),
            .count(cnt[r])
         );
      end
   end

`ifdef HAZARD_SB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stallCount <= '0;
         flushCount <= '0;
      end else begin
         if (flush) begin
            flushCount <= flushCount + CNT_W'(1);
         end
         if (hazard && !flush) begin
            stallCount <= stallCount + CNT_W'(1);
         end
      end
   end
`else
   assign stallCount = '0;
   assign flushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
// Expected stall counts are hand-derived from the producer latencies.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        dec_valid;
   logic [4:0]  dec_rs1Address;
   logic [4:0]  dec_rs2Address;
   logic        dec_rs1Used;
   logic        dec_rs2Used;
   logic [4:0]  dec_rdAddress;
   logic        dec_rdWriteEnable;
   logic [2:0]  dec_latency;
   logic        exe_isBranchOrJumpTaken;
   logic        dec_issue;
   logic        pcWriteEnable;
   logic        if_kill;
   logic        dec_kill;
   logic [31:0] stallCount;
   logic [31:0] flushCount;

   int checks = 0;
   int errors = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   hazard_scoreboard dut (
      .clk(clk),
      .rst(rst),
      .dec_valid(dec_valid),
      .dec_rs1Address(dec_rs1Address),
      .dec_rs2Address(dec_rs2Address),
      .dec_rs1Used(dec_rs1Used),
      .dec_rs2Used(dec_rs2Used),
      .dec_rdAddress(dec_rdAddress),
      .dec_rdWriteEnable(dec_rdWriteEnable),
      .dec_latency(dec_latency),
      .exe_isBranchOrJumpTaken(exe_isBranchOrJumpTaken),
      .dec_issue(dec_issue),
      .pcWriteEnable(pcWriteEnable),
      .if_kill(if_kill),
      .dec_kill(dec_kill),
      .stallCount(stallCount),
      .flushCount(flushCount)
   );

   always #5 clk = ~clk;

   task automatic drv(input logic v, input logic [4:0] a1, input logic u1,
                      input logic [4:0] a2, input logic u2,
                      input logic [4:0] rd, input logic we,
                      input logic [2:0] lat, input logic br);
      dec_valid               = v;
      dec_rs1Address          = a1;
      dec_rs1Used             = u1;
      dec_rs2Address          = a2;
      dec_rs2Used             = u2;
      dec_rdAddress           = rd;
      dec_rdWriteEnable       = we;
      dec_latency             = lat;
      exe_isBranchOrJumpTaken = br;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (n) cyc();
   endtask

   // Holds the current inputs until dec_issue, counting stall cycles.
   task automatic hold_until_issue(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (dec_issue === 1'b1) begin
            ok = 1'b1;
            cyc();
            break;
         end
         n++;
         cyc();
      end
   endtask

   task automatic test_reset();
      drv(1, 5, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (dec_issue !== 1'b1) begin
         errors++;
         $display("FAIL reset_issue got %b want 1", dec_issue);
      end
      checks++;
      if (pcWriteEnable !== 1'b1 || if_kill !== 1'b0 || dec_kill !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got pc=%b ifk=%b dk=%b want 1 0 0",
                  pcWriteEnable, if_kill, dec_kill);
      end
      checks++;
      if (stallCount !== 32'd0 || flushCount !== 32'd0) begin
         errors++;
         $display("FAIL reset_stats got %0d %0d want 0 0", stallCount, flushCount);
      end
      cyc();
      idle(1);
   endtask

   task automatic test_raw();
      int n;
      bit ok;
      drv(1, 0, 0, 0, 0, 5, 1, 3, 0);
      @(negedge clk);
      checks++;
      if (dec_issue !== 1'b1) begin
         errors++;
         $display("FAIL raw_producer_issue got %b want 1", dec_issue);
      end
      cyc();
      drv(1, 5, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (pcWriteEnable !== 1'b0 || if_kill !== 1'b1 ||
          dec_kill !== 1'b1 || dec_issue !== 1'b0) begin
         errors++;
         $display("FAIL raw_stall_ctrl got pc=%b ifk=%b dk=%b iss=%b want 0 1 1 0",
                  pcWriteEnable, if_kill, dec_kill, dec_issue);
      end
      cyc();
      hold_until_issue(n, ok);
      checks++;
      if (!ok || n + 1 != 2) begin
         errors++;
         $display("FAIL raw_stalls got %0d ok=%0b want 2", n + 1, ok);
      end
      exp_stall += 2;
      idle(5);
   endtask

   task automatic test_lat1();
      int n;
      bit ok;
      drv(1, 0, 0, 0, 0, 6, 1, 1, 0);
      cyc();
      drv(1, 0, 0, 6, 1, 0, 0, 0, 0);
      hold_until_issue(n, ok);
      checks++;
      if (!ok || n != 0) begin
         errors++;
         $display("FAIL lat1_stalls got %0d ok=%0b want 0", n, ok);
      end
      idle(5);
   endtask

   task automatic test_waw();
      int n;
      bit ok;
      drv(1, 0, 0, 0, 0, 7, 1, 4, 0);
      cyc();
      drv(1, 0, 0, 0, 0, 7, 1, 1, 0);
      hold_until_issue(n, ok);
      checks++;
      if (!ok || n != 2) begin
         errors++;
         $display("FAIL waw_stalls got %0d ok=%0b want 2", n, ok);
      end
      exp_stall += 2;
      drv(1, 7, 1, 0, 0, 0, 0, 0, 0);
      hold_until_issue(n, ok);
      checks++;
      if (!ok || n != 0) begin
         errors++;
         $display("FAIL waw_reader_stalls got %0d ok=%0b want 0", n, ok);
      end
      idle(5);
   endtask

   task automatic test_flush();
      int n;
      bit ok;
      drv(1, 0, 0, 0, 0, 3, 1, 4, 0);
      cyc();
      drv(1, 3, 1, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      checks++;
      if (pcWriteEnable !== 1'b1 || if_kill !== 1'b1 ||
          dec_kill !== 1'b1 || dec_issue !== 1'b0) begin
         errors++;
         $display("FAIL flush_ctrl got pc=%b ifk=%b dk=%b iss=%b want 1 1 1 0",
                  pcWriteEnable, if_kill, dec_kill, dec_issue);
      end
      exp_flush += 1;
      cyc();
      drv(1, 3, 1, 0, 0, 0, 0, 0, 0);
      hold_until_issue(n, ok);
      checks++;
      if (!ok || n != 2) begin
         errors++;
         $display("FAIL flush_then_stalls got %0d ok=%0b want 2", n, ok);
      end
      exp_stall += 2;
      idle(5);
   endtask

   task automatic test_x0();
      int n;
      bit ok;
      drv(1, 0, 1, 0, 0, 0, 1, 4, 0);
      @(negedge clk);
      checks++;
      if (dec_issue !== 1'b1) begin
         errors++;
         $display("FAIL x0_write_issue got %b want 1", dec_issue);
      end
      cyc();
      drv(1, 0, 1, 0, 1, 0, 1, 4, 0);
      hold_until_issue(n, ok);
      checks++;
      if (!ok || n != 0) begin
         errors++;
         $display("FAIL x0_reader_stalls got %0d ok=%0b want 0", n, ok);
      end
      idle(5);
   endtask

   task automatic test_src_used();
      int n;
      bit ok;
      drv(1, 0, 0, 0, 0, 11, 1, 3, 0);
      cyc();
      drv(1, 11, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (dec_issue !== 1'b1) begin
         errors++;
         $display("FAIL unused_src_issue got %b want 1", dec_issue);
      end
      cyc();
      drv(1, 0, 0, 11, 1, 0, 0, 0, 0);
      hold_until_issue(n, ok);
      checks++;
      if (!ok || n != 1) begin
         errors++;
         $display("FAIL rs2_stalls got %0d ok=%0b want 1", n, ok);
      end
      exp_stall += 1;
      idle(5);
   endtask

   task automatic test_same_reg();
      int n;
      bit ok;
      drv(1, 12, 1, 12, 1, 12, 1, 2, 0);
      @(negedge clk);
      checks++;
      if (dec_issue !== 1'b1) begin
         errors++;
         $display("FAIL same_reg_first_issue got %b want 1", dec_issue);
      end
      cyc();
      hold_until_issue(n, ok);
      checks++;
      if (!ok || n != 1) begin
         errors++;
         $display("FAIL same_reg_stalls got %0d ok=%0b want 1", n, ok);
      end
      exp_stall += 1;
      idle(5);
   endtask

   task automatic test_clamp();
      int n;
      bit ok;
      drv(1, 0, 0, 0, 0, 10, 1, 7, 0);
      cyc();
      drv(1, 10, 1, 0, 0, 0, 0, 0, 0);
      hold_until_issue(n, ok);
      checks++;
      if (!ok || n != 3) begin
         errors++;
         $display("FAIL clamp_stalls got %0d ok=%0b want 3", n, ok);
      end
      exp_stall += 3;
      idle(5);
   endtask

   task automatic test_stats();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
`ifdef HAZARD_SB_STATS_EN
      checks++;
      if (stallCount !== 32'(exp_stall)) begin
         errors++;
         $display("FAIL stall_count got %0d want %0d", stallCount, exp_stall);
      end
      checks++;
      if (flushCount !== 32'(exp_flush)) begin
         errors++;
         $display("FAIL flush_count got %0d want %0d", flushCount, exp_flush);
      end
`else
      checks++;
      if (stallCount !== 32'd0 || flushCount !== 32'd0) begin
         errors++;
         $display("FAIL stats_tied got %0d %0d want 0 0", stallCount, flushCount);
      end
`endif
      cyc();
   endtask

   task automatic test_reset_mid();
      drv(1, 0, 0, 0, 0, 9, 1, 4, 0);
      cyc();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      drv(1, 9, 1, 9, 1, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (dec_issue !== 1'b1 || pcWriteEnable !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_issue got iss=%b pc=%b want 1 1",
                  dec_issue, pcWriteEnable);
      end
      checks++;
      if (stallCount !== 32'd0 || flushCount !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_stats got %0d %0d want 0 0", stallCount, flushCount);
      end
      cyc();
      idle(2);
   endtask

   initial begin
      rst = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_raw();
      test_lat1();
      test_waw();
      test_flush();
      test_x0();
      test_src_used();
      test_same_reg();
      test_clamp();
      test_stats();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
